// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame sequencer and its frame buffer.
package fft_pkg;

  localparam int unsigned DefaultLgn  = 4;
  localparam int unsigned DefaultDw   = 16;
  localparam int unsigned FrameCntW   = 16;
  localparam int unsigned TimeoutCntW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StStart,
    StDrain,
    StWait
  } seq_state_e;

endpackage

// File: rtl/fft_frame_buf.sv
// Frame buffer: 2**LGN x DW storage, synchronous write, asynchronous read.
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int unsigned LGN = DefaultLgn,
  parameter int unsigned DW  = DefaultDw
) (
  input  logic           clk_i,
  input  logic           we_i,
  input  logic [LGN-1:0] waddr_i,
  input  logic [DW-1:0]  wdata_i,
  input  logic [LGN-1:0] raddr_i,
  output logic [DW-1:0]  rdata_o
);

  logic [DW-1:0] mem_q [2**LGN];

  // Contents are intentionally not reset; every slot is rewritten before it is read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_frame_sequencer.sv
// Collects a frame of 2**LGN samples, pulses start, streams the frame into the FFT core
// and waits for done under a timeout watchdog.
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned LGN     = DefaultLgn,
  parameter int unsigned DW      = DefaultDw,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [DW-1:0]        i_sample,
  input  logic                 i_sample_valid,
  output logic                 o_sample_ready,
  output logic                 o_fft_start,
  output logic [DW-1:0]        o_fft_val,
  output logic                 o_fft_valid,
  output logic                 o_fft_last,
  input  logic                 i_fft_ready,
  input  logic                 i_fft_done,
  output logic                 o_busy,
  output logic [FrameCntW-1:0] o_frame_count,
  output logic                 o_timeout,
  input  logic                 i_clear_err
);

  localparam int unsigned N = 2 ** LGN;
  localparam logic [LGN-1:0] LastIdx = LGN'(N - 1);
  localparam logic [TimeoutCntW-1:0] TimeoutLast = TimeoutCntW'(TIMEOUT - 1);

  seq_state_e             state_q, state_d;
  logic [LGN-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LGN-1:0]         rd_ptr_q, rd_ptr_d;
  logic [TimeoutCntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [FrameCntW-1:0]   frame_cnt_q, frame_cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   buf_we;
  logic [DW-1:0]          buf_rdata;

  fft_frame_buf #(
    .LGN (LGN),
    .DW  (DW)
  ) u_buf (
    .clk_i   (i_clk),
    .we_i    (buf_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_sample),
    .raddr_i (rd_ptr_q),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tmo_cnt_q   <= '0;
      frame_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tmo_cnt_q   <= tmo_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tmo_cnt_d   = tmo_cnt_q;
    frame_cnt_d = frame_cnt_q;
    // Clear is applied first so a same-cycle timeout set below takes priority.
    timeout_d   = timeout_q & ~i_clear_err;
    buf_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_enable) begin
          state_d = StFill;
        end
      end
      StFill: begin
        buf_we = i_sample_valid;
        if (!i_enable) begin
          // Partial frame is dropped even if a sample lands this cycle.
          wr_ptr_d = '0;
          state_d  = StIdle;
        end else if (i_sample_valid) begin
          if (wr_ptr_q == LastIdx) begin
            wr_ptr_d = '0;
            state_d  = StStart;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      StStart: begin
        state_d = StDrain;
      end
      StDrain: begin
        if (i_fft_ready) begin
          if (rd_ptr_q == LastIdx) begin
            rd_ptr_d = '0;
            state_d  = StWait;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      StWait: begin
        if (i_fft_done) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          tmo_cnt_d   = '0;
          state_d     = i_enable ? StFill : StIdle;
        end else if (tmo_cnt_q == TimeoutLast) begin
          timeout_d = 1'b1;
          tmo_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign o_sample_ready = (state_q == StFill);
  assign o_fft_start    = (state_q == StStart);
  assign o_fft_valid    = (state_q == StDrain);
  assign o_fft_last     = o_fft_valid && (rd_ptr_q == LastIdx);
  assign o_fft_val      = o_fft_valid ? buf_rdata : '0;
  assign o_busy         = (state_q != StIdle);
  assign o_frame_count  = frame_cnt_q;
  assign o_timeout      = timeout_q;

endmodule
